// File: rtl/psum_writeback.sv
// Drains a programmed number of psum rows from the corelet OFIFO into consecutive
// PMEM addresses, with optional per-lane ReLU, then pulses done.
module psum_writeback #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 11
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [addr_bw-1:0]      base_addr,
  input  logic [addr_bw:0]        num_rows,
  input  logic                    relu_en,
  input  logic                    ofifo_valid,
  input  logic [col*psum_bw-1:0]  ofifo_out,
  output logic                    ofifo_rd,
  output logic                    pmem_wr,
  output logic [addr_bw-1:0]      pmem_addr,
  output logic [col*psum_bw-1:0]  pmem_din,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              dbg_state
);

  localparam int DW = col * psum_bw;
  localparam logic [addr_bw-1:0] ADDR_ONE = addr_bw'(1);
  localparam logic [addr_bw:0]   ROWS_ONE = (addr_bw + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [addr_bw-1:0] addr_q, addr_d;
  logic [addr_bw:0]   remain_q, remain_d;
  logic               relu_q, relu_d;
  logic               wr_q, wr_d;
  logic [addr_bw-1:0] waddr_q, waddr_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [DW-1:0]      row_proc;
  logic               pop;

  // OFIFO handshake: ofifo_out is show-ahead data qualified by ofifo_valid; the head
  // is consumed on a clock edge exactly when ofifo_rd is high, and ofifo_rd is only
  // ever raised while ofifo_valid is high. Reset suppresses the pop so an abort
  // cannot consume a row it will never write.
  assign pop = (state_q == S_DRAIN) && ofifo_valid && (remain_q != '0) && !reset;

  always_comb begin
    row_proc = ofifo_out;
    for (int k = 0; k < col; k++) begin
      if (relu_q && ofifo_out[k*psum_bw + psum_bw - 1]) begin
        row_proc[k*psum_bw +: psum_bw] = '0;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    relu_d   = relu_q;
    wr_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          relu_d   = relu_en;
          addr_d   = base_addr;
          remain_d = num_rows;
          state_d  = (num_rows == '0) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop) begin
          wr_d     = 1'b1;
          waddr_d  = addr_q;
          wdata_d  = row_proc;
          addr_d   = addr_q + ADDR_ONE;
          remain_d = remain_q - ROWS_ONE;
          if (remain_q == ROWS_ONE) begin
            state_d = S_FLUSH;
          end
        end
      end
      // The final write is on the PMEM port during FLUSH.
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      relu_q   <= 1'b0;
      wr_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      relu_q   <= relu_d;
      wr_q     <= wr_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign ofifo_rd  = pop;
  assign pmem_wr   = wr_q;
  assign pmem_addr = waddr_q;
  assign pmem_din  = wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_psum_writeback.sv
// Self-checking bench for psum_writeback: an OFIFO model feeds rows, a scoreboard
// holds the expected PMEM writes, and cycle logs check pop/write/done timing.
module tb_psum_writeback;
  localparam int COL = 8;
  localparam int PBW = 16;
  localparam int AW  = 11;
  localparam int DW  = COL * PBW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_rows;
  logic          relu_en;
  logic          ofifo_valid;
  logic [DW-1:0] ofifo_out;
  logic          ofifo_rd;
  logic          pmem_wr;
  logic [AW-1:0] pmem_addr;
  logic [DW-1:0] pmem_din;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  psum_writeback #(.col(COL), .psum_bw(PBW), .addr_bw(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .num_rows   (num_rows),
    .relu_en    (relu_en),
    .ofifo_valid(ofifo_valid),
    .ofifo_out  (ofifo_out),
    .ofifo_rd   (ofifo_rd),
    .pmem_wr    (pmem_wr),
    .pmem_addr  (pmem_addr),
    .pmem_din   (pmem_din),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int cyc    = 0;
  int rd_ptr = 0;
  int wr_ptr = 0;
  logic          gate = 1'b0;
  logic [DW-1:0] src_mem [0:63];

  // OFIFO model: ring buffer, head popped on edges where ofifo_rd is high
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ofifo_rd) rd_ptr <= rd_ptr + 1;
  end
  assign ofifo_valid = gate && (rd_ptr != wr_ptr);
  assign ofifo_out   = src_mem[rd_ptr[5:0]];

  // Scoreboard state
  logic [AW+DW-1:0] exp_q[$];
  int               rd_log[$];
  int               wr_log[$];
  int               done_log[$];
  logic [AW-1:0]    next_addr;
  logic             cur_relu;
  logic [AW-1:0]    last_wr_addr;
  int               n_checks = 0;
  int               n_errors = 0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] relu_model(input logic [DW-1:0] row, input logic en);
    logic [DW-1:0] r;
    r = row;
    for (int k = 0; k < COL; k++) begin
      logic [PBW-1:0] lane;
      lane = row[k*PBW +: PBW];
      if (en && lane[PBW-1]) r[k*PBW +: PBW] = '0;
    end
    return r;
  endfunction

  // Sample outputs at the falling edge, then return just after the next rising edge
  task automatic tick();
    logic [AW+DW-1:0] e;
    @(negedge clk);
    if (ofifo_rd) begin
      rd_log.push_back(cyc);
      check("rd_needs_valid", ofifo_valid, 1);
    end
    if (pmem_wr) begin
      wr_log.push_back(cyc);
      last_wr_addr = pmem_addr;
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", pmem_addr, e[AW+DW-1:DW]);
        check("wr_data", pmem_din, e[DW-1:0]);
      end
    end
    if (done) begin
      done_log.push_back(cyc);
      check("busy_with_done", busy, 1);
    end
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic push_row_exp(input logic [DW-1:0] row, input logic [DW-1:0] exp_data);
    src_mem[wr_ptr[5:0]] = row;
    wr_ptr++;
    exp_q.push_back({next_addr, exp_data});
    next_addr = next_addr + 1'b1;
  endtask

  task automatic push_row(input logic [DW-1:0] row);
    push_row_exp(row, relu_model(row, cur_relu));
  endtask

  task automatic push_dummy(input logic [DW-1:0] row);
    src_mem[wr_ptr[5:0]] = row;
    wr_ptr++;
  endtask

  function automatic logic [DW-1:0] rand_row();
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic send_start(input logic [AW-1:0] b, input logic [AW:0] n, input logic r,
                            output int s);
    base_addr = b;
    num_rows  = n;
    relu_en   = r;
    start     = 1'b1;
    s         = cyc;
    tick();
    start     = 1'b0;
    base_addr = $urandom_range(0, 2047);
    num_rows  = $urandom_range(0, 15);
    relu_en   = $urandom_range(0, 1);
  endtask

  task automatic wait_done(input int d0, input int max, output int dc);
    for (int i = 0; i < max && done_log.size() <= d0; i++) tick();
    if (done_log.size() > d0) begin
      dc = done_log[d0];
    end else begin
      check("done_timeout", 0, 1);
      dc = -1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks %0d)", n_checks);
    $fatal(1);
  end

  initial begin
    int s, dc, r0, w0, d0, p0;
    logic [PBW-1:0] lanes_in  [8];
    logic [PBW-1:0] lanes_exp [8];
    logic [DW-1:0]  row_in, row_exp;

    for (int i = 0; i < 64; i++) src_mem[i] = '0;
    reset = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0; relu_en = 1'b0;
    next_addr = '0; cur_relu = 1'b0; last_wr_addr = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Idle after reset: outputs zero, a valid OFIFO is not popped
    push_dummy(rand_row());
    gate = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_outputs", {ofifo_rd, pmem_wr, pmem_addr, pmem_din, busy, done}, 0);
    end
    wr_ptr = rd_ptr;

    // Basic burst of four rows
    cur_relu = 1'b0; next_addr = 11'h010;
    for (int i = 0; i < 4; i++) push_row(rand_row());
    r0 = rd_log.size(); w0 = wr_log.size(); d0 = done_log.size();
    send_start(11'h010, 12'd4, 1'b0, s);
    wait_done(d0, 40, dc);
    check("b_busy_after", busy, 0);
    check("b_rd_cnt", rd_log.size() - r0, 4);
    check("b_wr_cnt", wr_log.size() - w0, 4);
    if (rd_log.size() - r0 == 4) begin
      check("b_first_rd", rd_log[r0], s + 1);
      check("b_last_rd", rd_log[r0+3], s + 4);
    end
    if (wr_log.size() - w0 == 4) begin
      check("b_first_wr", wr_log[w0], s + 2);
      check("b_last_wr", wr_log[w0+3], s + 5);
    end
    check("b_done_cyc", dc, s + 6);
    check("b_done_once", done_log.size() - d0, 1);
    check("b_sb_empty", exp_q.size(), 0);

    // Stall: valid pattern 1,0,0,1,1
    next_addr = 11'h100;
    for (int i = 0; i < 3; i++) push_row(rand_row());
    r0 = rd_log.size(); w0 = wr_log.size(); d0 = done_log.size();
    send_start(11'h100, 12'd3, 1'b0, s);
    tick();
    gate = 1'b0;
    tick(); tick();
    gate = 1'b1;
    wait_done(d0, 40, dc);
    check("s_rd_cnt", rd_log.size() - r0, 3);
    check("s_wr_cnt", wr_log.size() - w0, 3);
    if (wr_log.size() - w0 == 3) begin
      check("s_wr0", wr_log[w0], s + 2);
      check("s_wr1_after_gap", wr_log[w0+1], s + 5);
      check("s_wr2", wr_log[w0+2], s + 6);
    end
    check("s_done_cyc", dc, s + 7);
    check("s_sb_empty", exp_q.size(), 0);

    // ReLU on a fixed row plus one random row
    cur_relu = 1'b1; next_addr = 11'h040;
    lanes_in  = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h0001, 16'h0000, 16'hFFF0, 16'h1234, 16'h8001};
    lanes_exp = '{16'h0000, 16'h0000, 16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 16'h1234, 16'h0000};
    for (int k = 0; k < COL; k++) begin
      row_in[k*PBW +: PBW]  = lanes_in[k];
      row_exp[k*PBW +: PBW] = lanes_exp[k];
    end
    push_row_exp(row_in, row_exp);
    push_row(rand_row());
    d0 = done_log.size();
    send_start(11'h040, 12'd2, 1'b1, s);
    wait_done(d0, 40, dc);
    check("r_sb_empty", exp_q.size(), 0);
    cur_relu = 1'b0;

    // Zero rows: done right after start, nothing popped
    push_dummy(rand_row());
    r0 = rd_log.size();
    send_start(11'h222, 12'd0, 1'b0, s);
    check("z_done", done, 1);
    check("z_busy", busy, 1);
    tick();
    check("z_done_low", done, 0);
    check("z_busy_low", busy, 0);
    check("z_no_rd", rd_log.size() - r0, 0);
    wr_ptr = rd_ptr;

    // Address wrap
    next_addr = 11'h7FF;
    push_row(rand_row());
    push_row(rand_row());
    d0 = done_log.size();
    send_start(11'h7FF, 12'd2, 1'b0, s);
    wait_done(d0, 40, dc);
    check("w_last_addr", last_wr_addr, 11'h000);
    check("w_sb_empty", exp_q.size(), 0);

    // Start while busy is ignored
    next_addr = 11'h200;
    for (int i = 0; i < 4; i++) push_row(rand_row());
    for (int i = 0; i < 4; i++) push_dummy(rand_row());
    r0 = rd_log.size(); d0 = done_log.size();
    send_start(11'h200, 12'd4, 1'b0, s);
    tick();
    base_addr = 11'h300; num_rows = 12'd6; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(d0, 40, dc);
    repeat (3) tick();
    check("i_rd_cnt", rd_log.size() - r0, 4);
    check("i_done_once", done_log.size() - d0, 1);
    check("i_sb_empty", exp_q.size(), 0);
    wr_ptr = rd_ptr;

    // Reset after three pops of an eight-row burst
    next_addr = 11'h400;
    for (int i = 0; i < 8; i++) push_row(rand_row());
    p0 = rd_ptr; d0 = done_log.size();
    send_start(11'h400, 12'd8, 1'b0, s);
    for (int i = 0; i < 20 && (rd_ptr - p0) < 3; i++) tick();
    check("m_three_pops", rd_ptr - p0, 3);
    reset = 1'b1;
    tick();
    check("m_outputs_zero", {ofifo_rd, pmem_wr, pmem_addr, pmem_din, busy, done}, 0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (4) tick();
    check("m_no_more_pops", rd_ptr - p0, 3);
    check("m_no_done", done_log.size() - d0, 0);
    check("m_sb_left", exp_q.size(), 5);
    exp_q.delete();
    wr_ptr = rd_ptr;

    // Single row after the abort
    next_addr = 11'h055;
    push_row(rand_row());
    w0 = wr_log.size(); d0 = done_log.size();
    send_start(11'h055, 12'd1, 1'b0, s);
    wait_done(d0, 40, dc);
    check("a_wr_cnt", wr_log.size() - w0, 1);
    check("a_done_cyc", dc, s + 3);
    check("a_sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/psum_writeback.md
Name: psum_writeback

Overview:
- Drain stage directly downstream of the corelet OFIFO.
- On a start command it pops a programmed number of psum rows (col lanes × psum_bw each) whenever the OFIFO reports valid data.
- Optionally applies per-lane ReLU, then writes each row to consecutive addresses of the psum memory (PMEM).
- Reports busy and signals done with a one-cycle pulse.

Parameters:
- col, 8, number of psum lanes per OFIFO row
- psum_bw, 16, bit-width of each signed psum lane
- addr_bw, 11, PMEM address width

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle command pulse; sampled only in IDLE
- base_addr  input  addr_bw  first PMEM address; latched on accepted start
- num_rows  input  addr_bw+1  rows to drain; latched on accepted start
- relu_en  input  1  clamp negative lanes to 0; latched on accepted start
- ofifo_valid  input  1  OFIFO holds at least one row; ofifo_out is valid (show-ahead)
- ofifo_out  input  col*psum_bw  head row of the OFIFO; lane k at bits [k*psum_bw +: psum_bw]
- ofifo_rd  output  1  pop the OFIFO head at this clock edge
- pmem_wr  output  1  PMEM write enable, active-high
- pmem_addr  output  addr_bw  PMEM write address
- pmem_din  output  col*psum_bw  PMEM write data
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset values: ofifo_rd=0, pmem_wr=0, pmem_addr=0, pmem_din=0, busy=0, done=0. Internal counters clear to 0 and the state goes to IDLE.
- A reset asserted mid-operation aborts immediately. No further pops or writes occur and no done pulse is issued.
- States are IDLE, DRAIN, FLUSH, DONE.
- IDLE -> DRAIN on start when num_rows != 0: latch the inputs, set the address register to base_addr, set remaining to num_rows, set busy=1.
- IDLE -> DONE on start when num_rows == 0: busy=1 for exactly one cycle, no pops.
- In any state other than IDLE, start is ignored.
- DRAIN: ofifo_rd is combinational and equals ofifo_valid && (remaining != 0). It is never asserted when ofifo_valid is low.
- On each pop edge:
  - pmem_din <= processed ofifo_out
  - pmem_addr <= address register
  - pmem_wr <= 1
  - address register increments by 1
  - remaining decrements by 1
- pmem_wr deasserts on the next edge that has no pop.
- Write latency: one cycle from pop edge to PMEM write cycle. Back-to-back pops produce back-to-back writes with no bubbles.
- DRAIN -> FLUSH on the edge that pops the last row (remaining goes 1 -> 0).
- FLUSH: the last write is presented (pmem_wr=1). Go to DONE on the next edge.
- DONE: done=1 for one cycle, busy=1. Go to IDLE on the next edge, where busy=0.
- ReLU rule: when relu_en=1, each lane is treated as two's-complement; a lane with MSB=1 is written as 0, otherwise it passes unchanged. When relu_en=0, all lanes pass unchanged. No other width changes.
- Address wrap: the address register wraps modulo 2^addr_bw. 2047 + 1 = 0 with the default parameters. No error is flagged.
- OFIFO empty mid-burst: the block stalls in DRAIN with ofifo_rd=0 and pmem_wr=0 until ofifo_valid returns. There is no timeout.
- pmem_addr and pmem_din hold their last values while pmem_wr=0.

Test Plan:
- Reset, then idle for 5 cycles -> all outputs 0; ofifo_valid=1 produces no ofifo_rd.
- Basic burst: base_addr=0x010, num_rows=4, relu_en=0, ofifo_valid held high with rows R0..R3.
  - ofifo_rd high for 4 consecutive cycles.
  - pmem_wr high for the 4 cycles after that, at addresses 0x010..0x013 with data R0..R3.
  - done pulses once, 2 cycles after the last pop; busy then falls.
- Stall: num_rows=3, ofifo_valid toggles 1,0,0,1,1 -> exactly 3 pops and 3 writes at consecutive addresses; pmem_wr low during the gap; done after the third write.
- ReLU: relu_en=1, row lanes = {0x8000, 0xFFFF, 0x7FFF, 0x0001, 0x0000, 0xFFF0, 0x1234, 0x8001} -> pmem_din lanes = {0, 0, 0x7FFF, 0x0001, 0, 0, 0x1234, 0}.
- Edge commands:
  - num_rows=0 -> done one cycle after start, no ofifo_rd.
  - base_addr=0x7FF, num_rows=2 -> writes at 0x7FF then 0x000.
  - start pulsed while busy -> ignored; the row count is unchanged.
- Reset mid-burst: num_rows=8, reset asserted after 3 pops -> next cycle all outputs 0 and no done pulse. A subsequent start with num_rows=1 completes normally.
